// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detectors.
// State encoding, default sizing constants and the FSM state type.
package seq_det_pkg;

    // State encoding shared by the serial detectors
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEEN1 = 2'd1;
    localparam logic [1:0] COUNT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_SEEN1 = SEEN1,
        ST_COUNT = COUNT
    } gsd_state_e;

    // Default sizing
    localparam int GSD_MAX_GAP = 8;
    localparam int GSD_HIT_W   = 8;

endpackage : seq_det_pkg

// File: rtl/gap_counter.sv
// Loadable up-counter with a terminal compare against a run-time limit.
// load has priority over en; eq reflects the registered count.
module gap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         eq
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise increment when enabled
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign eq  = (cnt_q == limit);

endmodule : gap_counter

// File: rtl/gap_sequence_detector.sv
// Detects "1, exactly G zeros, 1" on a qualified serial input, with
// overlapping matches and a registered one-cycle hit pulse on y.
// G comes from gap_len, clamped to MAX_GAP, and is latched on the first
// zero after a 1 so a pattern in flight is immune to later gap_len changes.
// Optional feature macro: GSD_HIT_COUNT_EN adds a saturating hit_count.
module gap_sequence_detector
    import seq_det_pkg::*;
#(
    parameter int MAX_GAP = GSD_MAX_GAP,
`ifdef GSD_HIT_COUNT_EN
    parameter int HIT_W = GSD_HIT_W,
`endif
    localparam int CNT_W = $clog2(MAX_GAP + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             j,
    input  logic [CNT_W-1:0] gap_len,
    output logic             busy,
`ifdef GSD_HIT_COUNT_EN
    output logic [HIT_W-1:0] hit_count,
`endif
    output logic             y
);

    gsd_state_e       state_q;
    gsd_state_e       state_d;
    logic [CNT_W-1:0] gap_lat_q;
    logic [CNT_W-1:0] gap_lat_d;
    logic             y_q;
    logic             y_d;

    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] zcnt;
    logic             zcnt_eq;
    logic [CNT_W-1:0] gap_clamped;

    // Requested gap limited to what the counter supports
    always_comb begin
        gap_clamped = gap_len;
        if (gap_len > CNT_W'(MAX_GAP)) begin
            gap_clamped = CNT_W'(MAX_GAP);
        end
    end

    // Zero counter; zcnt never passes gap_lat because COUNT leaves on equality
    gap_counter #(
        .W (CNT_W)
    ) u_gap_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(1)),
        .en       (cnt_en),
        .limit    (gap_lat_q),
        .cnt      (zcnt),
        .eq       (zcnt_eq)
    );

    // Next-state, gap latch, counter control and hit decode on valid samples
    always_comb begin
        state_d   = state_q;
        gap_lat_d = gap_lat_q;
        y_d       = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (j) begin
                        state_d = ST_SEEN1;
                    end
                end
                ST_SEEN1: begin
                    if (j) begin
                        // Adjacent ones are a zero-length gap
                        y_d = (gap_len == '0);
                    end else begin
                        gap_lat_d = gap_clamped;
                        if (gap_clamped == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d  = ST_COUNT;
                            cnt_load = 1'b1;
                        end
                    end
                end
                ST_COUNT: begin
                    if (j) begin
                        // Closing 1 also opens the next pattern
                        state_d = ST_SEEN1;
                        y_d     = zcnt_eq;
                    end else if (zcnt_eq) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, gap latch and hit pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gap_lat_q <= '0;
            y_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_lat_q <= gap_lat_d;
            y_q       <= y_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign y    = y_q;

`ifdef GSD_HIT_COUNT_EN
    logic [HIT_W-1:0] hit_count_q;
    logic [HIT_W-1:0] hit_count_d;

    // Saturating count of hits, advanced together with the y pulse
    always_comb begin
        hit_count_d = hit_count_q;
        if (y_d && (hit_count_q != {HIT_W{1'b1}})) begin
            hit_count_d = hit_count_q + HIT_W'(1);
        end
    end

    // Hit counter register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q <= '0;
        end else begin
            hit_count_q <= hit_count_d;
        end
    end

    assign hit_count = hit_count_q;
`endif

endmodule : gap_sequence_detector

// File: tb/tb_gap_sequence_detector.sv
// Self-checking bench for gap_sequence_detector (MAX_GAP=8).
// A behavioural model predicts y/busy/hit count per driven sample and pushes
// them to a queue; each scenario task pops and compares after the clock edge.
module tb_gap_sequence_detector;

    localparam int TB_MAX_GAP = 8;
    localparam int TB_CNT_W   = 4;
    localparam int TB_HIT_W   = 2;
    localparam int TB_HIT_MAX = (1 << TB_HIT_W) - 1;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                j;
    logic [TB_CNT_W-1:0] gap_len;
    logic                busy;
    logic                y;
`ifdef GSD_HIT_COUNT_EN
    logic [TB_HIT_W-1:0] hit_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic y;
        logic busy;
        int   hits;
    } exp_t;

    exp_t exp_q[$];

    // Model state: seen a 1, zeros since that 1, latched gap, hit total
    bit m_have1;
    int m_zeros;
    int m_glat;
    int m_hits;

`ifdef GSD_HIT_COUNT_EN
    gap_sequence_detector #(
        .MAX_GAP (TB_MAX_GAP),
        .HIT_W   (TB_HIT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .j         (j),
        .gap_len   (gap_len),
        .busy      (busy),
        .hit_count (hit_count),
        .y         (y)
    );
`else
    gap_sequence_detector #(
        .MAX_GAP (TB_MAX_GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .j        (j),
        .gap_len  (gap_len),
        .busy     (busy),
        .y        (y)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_have1 = 0;
        m_zeros = 0;
        m_glat  = 0;
        m_hits  = 0;
        exp_q.delete();
    endtask

    // Drive one sample at a negedge, push the prediction, return at next negedge
    task automatic drive(input logic v, input logic b);
        exp_t e;
        int   gl;
        bit   hit;
        hit      = 0;
        in_valid = v;
        j        = b;
        gl       = int'(gap_len);
        if (v) begin
            if (b) begin
                if (m_have1 && m_zeros == 0 && gl == 0) hit = 1;
                if (m_have1 && m_zeros > 0 && m_zeros == m_glat) hit = 1;
                m_have1 = 1;
                m_zeros = 0;
            end else if (m_have1) begin
                if (m_zeros == 0) m_glat = (gl > TB_MAX_GAP) ? TB_MAX_GAP : gl;
                if (m_zeros <= m_glat) m_zeros++;
            end
        end
        if (hit && m_hits < TB_HIT_MAX) m_hits++;
        e.y    = hit;
        e.busy = m_have1 && (m_zeros == 0 || m_zeros <= m_glat);
        e.hits = m_hits;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        $display("txn v=%0b j=%0b gap_len=%0d -> y=%0b busy=%0b", v, b, gap_len, y, busy);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        j        = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        j        = 1'b0;
        gap_len  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (y !== 1'b0) begin errors++; $display("FAIL reset_y y=%0b expected 0", y); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy busy=%0b expected 0", busy); end
`ifdef GSD_HIT_COUNT_EN
        checks++;
        if (hit_count !== '0) begin errors++; $display("FAIL reset_hits hit_count=%0d expected 0", hit_count); end
`endif
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        bit   seq[$] = '{1, 0, 0, 0, 0, 0, 0, 1};
        exp_t e;
        int   pulses = 0;
        apply_reset();
        gap_len = TB_CNT_W'(6);
        foreach (seq[i]) begin
            drive(1'b1, seq[i]);
            e = exp_q.pop_front();
            if (y === 1'b1) pulses++;
            checks++;
            if (y !== e.y) begin errors++; $display("FAIL basic_y step %0d y=%0b expected %0b", i, y, e.y); end
            checks++;
            if (busy !== e.busy) begin errors++; $display("FAIL basic_busy step %0d busy=%0b expected %0b", i, busy, e.busy); end
        end
        // Pulse must be the cycle after the closing 1, and only then
        drive(1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (y !== 1'b0) begin errors++; $display("FAIL basic_pulse_width y=%0b expected 0", y); end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL basic_pulses count=%0d expected 1", pulses); end
    endtask

    task automatic test_overlap();
        bit   seq2[$] = '{1, 0, 0, 1, 0, 0, 1};
        bit   seq0[$] = '{1, 1, 1};
        exp_t e;
        int   pulses = 0;
        int   first  = -1;
        int   last   = -1;
        apply_reset();
        gap_len = TB_CNT_W'(2);
        foreach (seq2[i]) begin
            drive(1'b1, seq2[i]);
            e = exp_q.pop_front();
            if (y === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
                last = i;
            end
            checks++;
            if (y !== e.y) begin errors++; $display("FAIL overlap2_y step %0d y=%0b expected %0b", i, y, e.y); end
        end
        checks++;
        if (pulses != 2 || (last - first) != 3) begin
            errors++;
            $display("FAIL overlap2_spacing pulses=%0d gap=%0d expected 2 pulses 3 apart", pulses, last - first);
        end
        apply_reset();
        gap_len = '0;
        foreach (seq0[i]) begin
            drive(1'b1, seq0[i]);
            e = exp_q.pop_front();
            checks++;
            if (y !== e.y) begin errors++; $display("FAIL overlap0_y step %0d y=%0b expected %0b", i, y, e.y); end
            checks++;
            if (busy !== e.busy) begin errors++; $display("FAIL overlap0_busy step %0d busy=%0b expected %0b", i, busy, e.busy); end
        end
    endtask

    task automatic test_near_miss();
        bit   seq[$] = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        exp_t e;
        apply_reset();
        gap_len = TB_CNT_W'(3);
        foreach (seq[i]) begin
            drive(1'b1, seq[i]);
            e = exp_q.pop_front();
            checks++;
            if (y !== 1'b0 || e.y !== 1'b0) begin
                errors++;
                $display("FAIL near_miss_y step %0d y=%0b model=%0b expected 0", i, y, e.y);
            end
            checks++;
            if (busy !== e.busy) begin errors++; $display("FAIL near_miss_busy step %0d busy=%0b expected %0b", i, busy, e.busy); end
        end
    endtask

    task automatic test_valid_gaps();
        bit   seq[$] = '{1, 0, 0, 1};
        exp_t e;
        int   pulses = 0;
        apply_reset();
        gap_len = TB_CNT_W'(2);
        foreach (seq[i]) begin
            drive(1'b1, seq[i]);
            e = exp_q.pop_front();
            if (y === 1'b1) pulses++;
            checks++;
            if (y !== e.y) begin errors++; $display("FAIL bubble_y step %0d y=%0b expected %0b", i, y, e.y); end
            // Change the requested gap mid-COUNT; pattern must still close at 2
            if (i == 1) gap_len = TB_CNT_W'(5);
            drive(1'b0, 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (y !== 1'b0) begin errors++; $display("FAIL bubble_idle_y step %0d y=%0b expected 0", i, y); end
            checks++;
            if (busy !== e.busy) begin errors++; $display("FAIL bubble_busy step %0d busy=%0b expected %0b", i, busy, e.busy); end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL bubble_pulses count=%0d expected 1", pulses); end
    endtask

    task automatic test_async_reset();
        bit   pre[$]  = '{1, 0, 0};
        bit   post[$] = '{0, 1, 0};
        exp_t e;
        apply_reset();
        gap_len = TB_CNT_W'(3);
        foreach (pre[i]) begin
            drive(1'b1, pre[i]);
            e = exp_q.pop_front();
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy busy=%0b expected 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy busy=%0b expected 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        foreach (post[i]) begin
            drive(1'b1, post[i]);
            e = exp_q.pop_front();
            checks++;
            if (y !== 1'b0 || e.y !== 1'b0) begin
                errors++;
                $display("FAIL areset_post_y step %0d y=%0b model=%0b expected 0", i, y, e.y);
            end
        end
        // Reset while y is high clears it without waiting for a clock
        apply_reset();
        gap_len = '0;
        drive(1'b1, 1'b1);
        e = exp_q.pop_front();
        drive(1'b1, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (y !== 1'b1) begin errors++; $display("FAIL areset_pre_y y=%0b expected 1", y); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (y !== 1'b0) begin errors++; $display("FAIL areset_y y=%0b expected 0", y); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_clamp();
        bit   seq[$];
        exp_t e;
        int   pulses;
        // 8 zeros hits, 9 and 7 zeros do not, with gap_len=15
        for (int z = 7; z <= 9; z++) begin
            apply_reset();
            gap_len = TB_CNT_W'(15);
            seq.delete();
            seq.push_back(1);
            for (int k = 0; k < z; k++) seq.push_back(0);
            seq.push_back(1);
            pulses = 0;
            foreach (seq[i]) begin
                drive(1'b1, seq[i]);
                e = exp_q.pop_front();
                if (y === 1'b1) pulses++;
                checks++;
                if (y !== e.y) begin errors++; $display("FAIL clamp_y zeros=%0d step %0d y=%0b expected %0b", z, i, y, e.y); end
            end
            checks++;
            if (pulses != ((z == 8) ? 1 : 0)) begin
                errors++;
                $display("FAIL clamp_pulses zeros=%0d count=%0d expected %0d", z, pulses, (z == 8) ? 1 : 0);
            end
        end
    endtask

`ifdef GSD_HIT_COUNT_EN
    task automatic test_hit_count();
        exp_t e;
        int   req[5] = '{1, 2, 3, 3, 3};
        apply_reset();
        gap_len = '0;
        drive(1'b1, 1'b1);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1);
            e = exp_q.pop_front();
            checks++;
            if (int'(hit_count) != e.hits || e.hits != req[i]) begin
                errors++;
                $display("FAIL hit_count hit %0d hit_count=%0d expected %0d", i, hit_count, req[i]);
            end
        end
        // Holds when no hit
        drive(1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (hit_count !== 2'd3) begin errors++; $display("FAIL hit_count_hold hit_count=%0d expected 3", hit_count); end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        j        = 1'b0;
        gap_len  = '0;
        model_reset();
        test_reset();
        test_basic();
        test_overlap();
        test_near_miss();
        test_valid_gaps();
        test_async_reset();
        test_clamp();
`ifdef GSD_HIT_COUNT_EN
        test_hit_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gap_sequence_detector
